// File: rtl/spi_nor_crc_loader.sv
// Boot loader: streams a fixed-length image from SPI NOR flash into BRAM
// and checks it against the big-endian CRC-16 stored right after it.
module spi_nor_crc_loader #(
    parameter logic [15:0] mem_addr = 16'h8000,
    parameter int unsigned length   = 'h4000,
    parameter int unsigned a_bits   = 14,
    parameter int unsigned cs_setup = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [23:0]       spi_addr,
    output logic              spi_req,
    input  logic              spi_ack,
    output logic [7:0]        spi_d,
    input  logic [7:0]        spi_q,
    output logic              spi_cs_n,
    output logic [a_bits-1:0] mem_a,
    output logic [7:0]        mem_q,
    output logic              mem_strobe,
    output logic              done,
    output logic              error,
    output logic [15:0]       crc
);

    localparam int unsigned cw = a_bits + 1;
    localparam int unsigned sw = (cs_setup > 1) ? $clog2(cs_setup) : 1;
    localparam logic [a_bits-1:0] base = a_bits'(mem_addr);
    localparam logic [cw-1:0] last_byte = cw'(length - 1);
    localparam logic [sw-1:0] setup_last = sw'(cs_setup - 1);

    typedef enum logic [3:0] {
        IDLE, SETUP, CMD, A2, A1, A0, DATA, CRCH, CRCL, FIN
    } state_t;

    state_t state, state_nx;

    logic [23:0]       addr_r, addr_nx;
    logic [sw-1:0]     scnt, scnt_nx;
    logic [cw-1:0]     cnt, cnt_nx;
    logic [7:0]        stored_hi, stored_nx;
    logic              req_nx;
    logic [7:0]        d_nx;
    logic              cs_n_nx;
    logic [a_bits-1:0] a_nx;
    logic [7:0]        q_nx;
    logic              strobe_nx;
    logic              done_nx;
    logic              error_nx;
    logic [15:0]       crc_nx;
    logic              take;

    // CRC-16/CCITT-FALSE, one byte folded MSB-first
    function automatic logic [15:0] crc_byte(
        input logic [15:0] c,
        input logic [7:0]  b
    );
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++)
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            addr_r     <= '0;
            scnt       <= '0;
            cnt        <= '0;
            stored_hi  <= '0;
            spi_req    <= 1'b0;
            spi_d      <= 8'h00;
            spi_cs_n   <= 1'b1;
            mem_a      <= '0;
            mem_q      <= 8'h00;
            mem_strobe <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            crc        <= 16'hFFFF;
        end else begin
            state      <= state_nx;
            addr_r     <= addr_nx;
            scnt       <= scnt_nx;
            cnt        <= cnt_nx;
            stored_hi  <= stored_nx;
            spi_req    <= req_nx;
            spi_d      <= d_nx;
            spi_cs_n   <= cs_n_nx;
            mem_a      <= a_nx;
            mem_q      <= q_nx;
            mem_strobe <= strobe_nx;
            done       <= done_nx;
            error      <= error_nx;
            crc        <= crc_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        addr_nx   = addr_r;
        scnt_nx   = scnt;
        cnt_nx    = cnt;
        stored_nx = stored_hi;
        req_nx    = spi_req;
        d_nx      = spi_d;
        cs_n_nx   = spi_cs_n;
        a_nx      = mem_a;
        q_nx      = mem_q;
        strobe_nx = 1'b0;
        done_nx   = done;
        error_nx  = error;
        crc_nx    = crc;
        // acks only count while a transfer is actually requested
        take      = spi_req && spi_ack;

        unique case (state)
            IDLE: begin
                addr_nx = spi_addr;
                cs_n_nx = 1'b0;
                if (cs_setup == 0) begin
                    state_nx = CMD;
                    req_nx   = 1'b1;
                    d_nx     = 8'h03;
                end else begin
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                if (scnt == setup_last) begin
                    scnt_nx  = '0;
                    state_nx = CMD;
                    req_nx   = 1'b1;
                    d_nx     = 8'h03;
                end else begin
                    scnt_nx = scnt + 1'b1;
                end
            end
            CMD: if (take) begin
                state_nx = A2;
                d_nx     = addr_r[23:16];
            end
            A2: if (take) begin
                state_nx = A1;
                d_nx     = addr_r[15:8];
            end
            A1: if (take) begin
                state_nx = A0;
                d_nx     = addr_r[7:0];
            end
            A0: if (take) begin
                state_nx = DATA;
                d_nx     = 8'h00;
            end
            DATA: if (take) begin
                q_nx      = spi_q;
                a_nx      = base + cnt[a_bits-1:0];
                strobe_nx = 1'b1;
                crc_nx    = crc_byte(crc, spi_q);
                cnt_nx    = cnt + 1'b1;
                if (cnt == last_byte)
                    state_nx = CRCH;
            end
            CRCH: if (take) begin
                stored_nx = spi_q;
                state_nx  = CRCL;
            end
            CRCL: if (take) begin
                state_nx = FIN;
                req_nx   = 1'b0;
                cs_n_nx  = 1'b1;
                done_nx  = 1'b1;
                error_nx = ({stored_hi, spi_q} != crc);
            end
            FIN: begin
                req_nx  = 1'b0;
                cs_n_nx = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_nor_crc_loader.sv
// Bench for spi_nor_crc_loader: flash slave models, BRAM scoreboard and
// a table-driven CRC reference; small wrap/stall instance plus default one.
module tb_spi_nor_crc_loader;

    localparam int          AB     = 14;
    localparam int          CSS    = 4;
    localparam int          LEN_A  = 9;
    localparam int          BASE_A = 'h3FFE;
    localparam int          LEN_B  = 16384;
    localparam int          BASE_B = 'h8000;
    localparam logic [23:0] ADDR_A = 24'hAABBCC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic          rst_a_n, ack_a, req_a, cs_n_a, stb_a, done_a, err_a;
    logic [7:0]    q_a, d_a, mq_a;
    logic [AB-1:0] ma_a;
    logic [15:0]   crc_a;

    logic          rst_b_n, ack_b, req_b, cs_n_b, stb_b, done_b, err_b;
    logic [7:0]    q_b, d_b, mq_b;
    logic [AB-1:0] ma_b;
    logic [15:0]   crc_b;
    logic [23:0]   addr_b;

    logic [7:0]  img_a[$];
    logic [7:0]  img_b[$];
    logic [15:0] stored_a, stored_b;
    logic [15:0] tab[256];

    logic [AB+7:0] exp_a[$];
    logic [AB+7:0] exp_b[$];
    int acks_a = 0, lasts_a = 0, nstrobe_a = 0;
    int acks_b = 0, lasts_b = 0, nstrobe_b = 0;
    bit seen_b[LEN_B];

    spi_nor_crc_loader #(
        .mem_addr (16'(BASE_A)),
        .length   (LEN_A),
        .a_bits   (AB),
        .cs_setup (CSS)
    ) dut_a (
        .clk        (clk),
        .reset_n    (rst_a_n),
        .spi_addr   (ADDR_A),
        .spi_req    (req_a),
        .spi_ack    (ack_a),
        .spi_d      (d_a),
        .spi_q      (q_a),
        .spi_cs_n   (cs_n_a),
        .mem_a      (ma_a),
        .mem_q      (mq_a),
        .mem_strobe (stb_a),
        .done       (done_a),
        .error      (err_a),
        .crc        (crc_a)
    );

    spi_nor_crc_loader dut_b (
        .clk        (clk),
        .reset_n    (rst_b_n),
        .spi_addr   (addr_b),
        .spi_req    (req_b),
        .spi_ack    (ack_b),
        .spi_d      (d_b),
        .spi_q      (q_b),
        .spi_cs_n   (cs_n_b),
        .mem_a      (ma_b),
        .mem_q      (mq_b),
        .mem_strobe (stb_b),
        .done       (done_b),
        .error      (err_b),
        .crc        (crc_b)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rst(input string t, input logic req,
                           input logic [7:0] d, input logic csn,
                           input logic [AB-1:0] ma, input logic [7:0] mq,
                           input logic stb, input logic dn, input logic er,
                           input logic [15:0] c);
        chk({t, "_req"}, req, 0);
        chk({t, "_d"}, d, 0);
        chk({t, "_csn"}, csn, 1);
        chk({t, "_mema"}, ma, 0);
        chk({t, "_memq"}, mq, 0);
        chk({t, "_strobe"}, stb, 0);
        chk({t, "_done"}, dn, 0);
        chk({t, "_error"}, er, 0);
        chk({t, "_crc"}, c, 16'hFFFF);
    endtask

    // Table built from linearity over GF(2): entries for single bits, XORed
    function automatic void build_tab();
        logic [15:0] pw[8];
        pw[0] = 16'h1021;
        for (int k = 1; k < 8; k++)
            pw[k] = pw[k-1][15] ? ((pw[k-1] << 1) ^ 16'h1021) : (pw[k-1] << 1);
        for (int b = 0; b < 256; b++) begin
            tab[b] = 16'h0000;
            for (int k = 0; k < 8; k++)
                if (((b >> k) & 1) == 1) tab[b] = tab[b] ^ pw[k];
        end
    endfunction

    function automatic logic [15:0] crc_ref(input logic [7:0] m[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (m[i]) c = (c << 8) ^ tab[c[15:8] ^ m[i]];
        return c;
    endfunction

    function automatic logic [7:0] mosi_exp(input int idx,
                                            input logic [23:0] a);
        if (idx == 0) return 8'h03;
        if (idx == 1) return a[23:16];
        if (idx == 2) return a[15:8];
        if (idx == 3) return a[7:0];
        return 8'h00;
    endfunction

    function automatic logic [AB-1:0] wr_addr(input int base, input int k);
        return AB'((base + k) % (1 << AB));
    endfunction

    // Flash slave A: random stall, stray acks whenever no request is open
    initial begin : slave_a
        int idx, stall;
        bit busy;
        logic [7:0] held;
        idx = 0; stall = 0; busy = 0; held = 8'h00;
        ack_a = 1'b0; q_a = 8'h00;
        forever begin
            @(negedge clk);
            ack_a = 1'b0;
            if (!rst_a_n) exp_a.delete();
            if (cs_n_a) idx = 0;
            if (!req_a) begin
                busy = 0;
                if ($urandom_range(0, 3) == 0) begin
                    ack_a = 1'b1;
                    q_a = 8'($urandom);
                end
            end else begin
                if (!busy) begin
                    busy = 1;
                    held = d_a;
                    stall = $urandom_range(0, 40);
                end
                chk("d_stable_a", d_a, held);
                if (stall > 0) begin
                    stall--;
                end else begin
                    chk("mosi_a", d_a, mosi_exp(idx, ADDR_A));
                    chk("extra_byte_a", idx <= LEN_A + 5, 1);
                    if (idx >= 4 && idx < 4 + LEN_A) begin
                        q_a = img_a[idx-4];
                        exp_a.push_back({wr_addr(BASE_A, idx - 4), q_a});
                        acks_a++;
                    end else if (idx == LEN_A + 4) begin
                        q_a = stored_a[15:8];
                    end else if (idx == LEN_A + 5) begin
                        q_a = stored_a[7:0];
                        lasts_a++;
                    end else begin
                        q_a = 8'($urandom);
                    end
                    ack_a = 1'b1;
                    idx++;
                    busy = 0;
                end
            end
        end
    end

    // Flash slave B: acks every requested byte immediately
    initial begin : slave_b
        int idx;
        idx = 0;
        ack_b = 1'b0; q_b = 8'h00;
        forever begin
            @(negedge clk);
            ack_b = 1'b0;
            if (!rst_b_n) exp_b.delete();
            if (cs_n_b) idx = 0;
            if (req_b) begin
                chk("mosi_b", d_b, mosi_exp(idx, addr_b));
                chk("extra_byte_b", idx <= LEN_B + 5, 1);
                if (idx >= 4 && idx < 4 + LEN_B) begin
                    q_b = img_b[idx-4];
                    exp_b.push_back({wr_addr(BASE_B, idx - 4), q_b});
                    acks_b++;
                end else if (idx == LEN_B + 4) begin
                    q_b = stored_b[15:8];
                end else if (idx == LEN_B + 5) begin
                    q_b = stored_b[7:0];
                    lasts_b++;
                end else begin
                    q_b = 8'($urandom);
                end
                ack_b = 1'b1;
                idx++;
            end
        end
    end

    initial begin : mon_a
        int seen, lseen;
        logic [AB+7:0] e;
        seen = 0; lseen = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_a_n) begin
                seen = acks_a;
                lseen = lasts_a;
            end else begin
                chk("strobe_a", stb_a, acks_a != seen);
                seen = acks_a;
                if (stb_a) begin
                    nstrobe_a++;
                    if (exp_a.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_a: write at %0h not expected", ma_a);
                    end else begin
                        e = exp_a.pop_front();
                        chk("mem_a_a", ma_a, e[AB+7:8]);
                        chk("mem_q_a", mq_a, e[7:0]);
                    end
                end
                if (lasts_a != lseen) begin
                    lseen = lasts_a;
                    chk("fin_done_a", done_a, 1);
                    chk("fin_csn_a", cs_n_a, 1);
                    chk("fin_req_a", req_a, 0);
                end
            end
        end
    end

    initial begin : mon_b
        int seen, lseen;
        logic [AB+7:0] e;
        seen = 0; lseen = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_b_n) begin
                seen = acks_b;
                lseen = lasts_b;
            end else begin
                chk("strobe_b", stb_b, acks_b != seen);
                seen = acks_b;
                if (stb_b) begin
                    nstrobe_b++;
                    chk("cover_dup_b", seen_b[ma_b], 0);
                    seen_b[ma_b] = 1'b1;
                    if (exp_b.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_b: write at %0h not expected", ma_b);
                    end else begin
                        e = exp_b.pop_front();
                        chk("mem_a_b", ma_b, e[AB+7:8]);
                        chk("mem_q_b", mq_b, e[7:0]);
                    end
                end
                if (lasts_b != lseen) begin
                    lseen = lasts_b;
                    chk("fin_done_b", done_b, 1);
                    chk("fin_csn_b", cs_n_b, 1);
                end
            end
        end
    end

    initial begin : main
        int s0, n, nb, cov;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        build_tab();
        img_a = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                  8'h36, 8'h37, 8'h38, 8'h39};
        stored_a = 16'h29B1;
        addr_b = 24'($urandom);
        for (int i = 0; i < LEN_B; i++) img_b.push_back(8'($urandom));
        stored_b = crc_ref(img_b);
        #22;
        chk_rst("rst_a", req_a, d_a, cs_n_a, ma_a, mq_a, stb_a,
                done_a, err_a, crc_a);
        chk_rst("rst_b", req_b, d_b, cs_n_b, ma_b, mq_b, stb_b,
                done_b, err_b, crc_b);
        @(negedge clk);
        #2;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        fork
            begin : seq_a
                s0 = nstrobe_a;
                n = 0;
                while (!done_a && n < 3000) begin
                    @(negedge clk);
                    n++;
                end
                chk("done_a1", done_a, 1);
                chk("crc_a1_check_value", crc_a, 16'h29B1);
                chk("crc_a1_model", crc_a, crc_ref(img_a));
                chk("error_a1", err_a, 0);
                chk("csn_a1", cs_n_a, 1);
                chk("writes_a1", nstrobe_a - s0, LEN_A);
                chk("sb_empty_a1", exp_a.size(), 0);
                repeat (20) @(negedge clk);
                chk("sticky_a1", {done_a, err_a}, 2'b10);

                #2;
                rst_a_n = 1'b0;
                stored_a = 16'h29B0;
                repeat (3) @(negedge clk);
                #2;
                rst_a_n = 1'b1;
                s0 = nstrobe_a;
                n = 0;
                while ((nstrobe_a - s0) < 5 && n < 3000) begin
                    @(negedge clk);
                    n++;
                end
                chk("mid_reached_a", (nstrobe_a - s0) >= 5, 1);
                #2;
                rst_a_n = 1'b0;
                #1;
                chk_rst("midrst_a", req_a, d_a, cs_n_a, ma_a, mq_a, stb_a,
                        done_a, err_a, crc_a);
                repeat (3) @(negedge clk);
                #2;
                rst_a_n = 1'b1;
                s0 = nstrobe_a;
                n = 0;
                while (!done_a && n < 3000) begin
                    @(negedge clk);
                    n++;
                end
                chk("done_a2", done_a, 1);
                chk("error_a2", err_a, 1);
                chk("crc_a2", crc_a, crc_ref(img_a));
                chk("writes_a2", nstrobe_a - s0, LEN_A);
                chk("sb_empty_a2", exp_a.size(), 0);
            end
            begin : seq_b
                nb = 0;
                while (!done_b && nb < 20000) begin
                    @(negedge clk);
                    nb++;
                end
                chk("done_b", done_b, 1);
                chk("load_time_b", nb <= CSS + 4 + LEN_B + 2 + 2, 1);
                chk("error_b", err_b, 0);
                chk("crc_b", crc_b, stored_b);
                chk("writes_b", nstrobe_b, LEN_B);
                cov = 0;
                foreach (seen_b[i]) if (seen_b[i]) cov++;
                chk("coverage_b", cov, LEN_B);
                chk("sb_empty_b", exp_b.size(), 0);
            end
        join
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
